// File: rtl/axi4_ring_sched_if.sv
// Command port between the ring scheduler and the AXI4 burst master.
// The scheduler is the master side; the burst engine is the slave side.
interface axi4_ring_sched_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_wr;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic                  cmd_done;
   logic                  cmd_error;

   modport master (
      output cmd_valid,
      output cmd_wr,
      output cmd_addr,
      input  cmd_ready,
      input  cmd_done,
      input  cmd_error
   );

   modport slave (
      input  cmd_valid,
      input  cmd_wr,
      input  cmd_addr,
      output cmd_ready,
      output cmd_done,
      output cmd_error
   );
endinterface

// File: rtl/axi4_ring_sched.sv
// Schedules write/read bursts so external memory acts as a ring buffer
// between an ingress FIFO and an egress FIFO.
module axi4_ring_sched #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] RANGE_ADDR = 32'h0000_0800,
   parameter int          BURST_LEN  = 8,
   parameter int          DATA_WIDTH = 256,
   parameter int          ADDR_WIDTH = 32,
   localparam int         BURST_BYTES = BURST_LEN * DATA_WIDTH / 8,
   localparam int         SLOTS = int'(RANGE_ADDR) / BURST_BYTES,
   localparam int         LW = $clog2(SLOTS) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                flush,
   input  logic                err_clr,
   input  logic                in_prog_empty,
   input  logic                out_prog_full,
   axi4_ring_sched_if.master   cmd,
   output logic [LW-1:0]       level,
   output logic                ring_full,
   output logic                ring_empty,
   output logic                busy,
   output logic                err
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ERR
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] LIMIT =
      ADDR_WIDTH'(BASE_ADDR + RANGE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_BYTES);
   localparam logic [LW-1:0] SLOTS_L = LW'(SLOTS);

   state_t                state, state_n;
   logic                  wr_q, wr_n;
   logic [ADDR_WIDTH-1:0] addr_q, addr_n;
   logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n;
   logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_n;
   logic [ADDR_WIDTH-1:0] wr_adv, rd_adv;
   logic [LW-1:0]         level_n;
   logic                  last_wr, last_wr_n;
   logic                  flush_pend, flush_pend_n;
   logic                  err_n;
   logic                  wr_elig, rd_elig, grant_wr;

   assign wr_elig  = enable & ~in_prog_empty & ~ring_full;
   assign rd_elig  = enable & ~out_prog_full & ~ring_empty;
   // On a tie, take the direction opposite to the last accepted grant.
   assign grant_wr = wr_elig & (~rd_elig | ~last_wr);

   assign wr_adv = (wr_ptr + STEP == LIMIT) ? BASE : wr_ptr + STEP;
   assign rd_adv = (rd_ptr + STEP == LIMIT) ? BASE : rd_ptr + STEP;

   assign cmd.cmd_wr   = wr_q;
   assign cmd.cmd_addr = addr_q;

   always_comb begin
      state_n      = state;
      wr_n         = wr_q;
      addr_n       = addr_q;
      wr_ptr_n     = wr_ptr;
      rd_ptr_n     = rd_ptr;
      level_n      = level;
      last_wr_n    = last_wr;
      flush_pend_n = flush_pend;
      err_n        = err;
      unique case (state)
         IDLE: begin
            if (flush) begin
               wr_ptr_n = BASE;
               rd_ptr_n = BASE;
               level_n  = '0;
            end else if (wr_elig | rd_elig) begin
               wr_n    = grant_wr;
               addr_n  = grant_wr ? wr_ptr : rd_ptr;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (flush) flush_pend_n = 1'b1;
            if (cmd.cmd_ready) begin
               last_wr_n = wr_q;
               state_n   = WAIT;
            end
         end
         WAIT: begin
            if (flush) flush_pend_n = 1'b1;
            if (cmd.cmd_done) begin
               if (cmd.cmd_error) begin
                  err_n   = 1'b1;
                  state_n = ERR;
               end else begin
                  state_n = IDLE;
                  if (wr_q) begin
                     wr_ptr_n = wr_adv;
                     if (level != SLOTS_L) level_n = level + 1'b1;
                  end else begin
                     rd_ptr_n = rd_adv;
                     if (level != '0) level_n = level - 1'b1;
                  end
               end
               // A pending flush overrides this burst's bookkeeping.
               if (flush_pend | flush) begin
                  wr_ptr_n     = BASE;
                  rd_ptr_n     = BASE;
                  level_n      = '0;
                  flush_pend_n = 1'b0;
               end
            end
         end
         ERR: begin
            if (flush) begin
               wr_ptr_n = BASE;
               rd_ptr_n = BASE;
               level_n  = '0;
            end
            if (err_clr) begin
               err_n   = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         wr_q          <= 1'b0;
         addr_q        <= BASE;
         wr_ptr        <= BASE;
         rd_ptr        <= BASE;
         level         <= '0;
         last_wr       <= 1'b0;
         flush_pend    <= 1'b0;
         err           <= 1'b0;
         cmd.cmd_valid <= 1'b0;
         busy          <= 1'b0;
         ring_full     <= 1'b0;
         ring_empty    <= 1'b1;
      end else begin
         state         <= state_n;
         wr_q          <= wr_n;
         addr_q        <= addr_n;
         wr_ptr        <= wr_ptr_n;
         rd_ptr        <= rd_ptr_n;
         level         <= level_n;
         last_wr       <= last_wr_n;
         flush_pend    <= flush_pend_n;
         err           <= err_n;
         cmd.cmd_valid <= (state_n == ISSUE);
         busy          <= (state_n != IDLE);
         ring_full     <= (level_n == SLOTS_L);
         ring_empty    <= (level_n == '0);
      end
   end

endmodule

// File: tb/tb_axi4_ring_sched.sv
// Directed bench for axi4_ring_sched acting as a simple burst master.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi4_ring_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable, flush, err_clr;
   logic       in_prog_empty, out_prog_full;
   logic [3:0] level;
   logic       ring_full, ring_empty, busy, err;
   int         checks = 0;
   int         errors = 0;

   axi4_ring_sched_if #(.ADDR_WIDTH(32)) c ();

   axi4_ring_sched dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .flush         (flush),
      .err_clr       (err_clr),
      .in_prog_empty (in_prog_empty),
      .out_prog_full (out_prog_full),
      .cmd           (c.master),
      .level         (level),
      .ring_full     (ring_full),
      .ring_empty    (ring_empty),
      .busy          (busy),
      .err           (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cmd(input logic exp_wr, input logic [31:0] exp_addr);
      int n = 0;
      while (c.cmd_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_valid_seen", 32'(c.cmd_valid), 32'd1);
      chk("cmd_wr", 32'(c.cmd_wr), 32'(exp_wr));
      chk("cmd_addr", c.cmd_addr, exp_addr);
   endtask

   task automatic handshake();
      c.cmd_ready = 1'b1;
      @(negedge clk);
      c.cmd_ready = 1'b0;
      chk("valid_drop", 32'(c.cmd_valid), 32'd0);
   endtask

   task automatic finish_cmd(input logic e);
      c.cmd_done  = 1'b1;
      c.cmd_error = e;
      @(negedge clk);
      c.cmd_done  = 1'b0;
      c.cmd_error = 1'b0;
   endtask

   task automatic do_cmd(input logic exp_wr, input logic [31:0] exp_addr,
                         input logic e);
      wait_cmd(exp_wr, exp_addr);
      handshake();
      finish_cmd(e);
   endtask

   task automatic chk_reset_outs();
      chk("rst_valid", 32'(c.cmd_valid), 32'd0);
      chk("rst_wr", 32'(c.cmd_wr), 32'd0);
      chk("rst_addr", c.cmd_addr, 32'h0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_full", 32'(ring_full), 32'd0);
      chk("rst_empty", 32'(ring_empty), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      flush = 1'b0;
      err_clr = 1'b0;
      in_prog_empty = 1'b1;
      out_prog_full = 1'b1;
      c.cmd_ready = 1'b0;
      c.cmd_done = 1'b0;
      c.cmd_error = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outs();
      rst = 1'b0;
      @(negedge clk);

      // Writes only: fill the ring.
      enable = 1'b1;
      in_prog_empty = 1'b0;
      for (int i = 0; i < 8; i++) do_cmd(1'b1, 32'(i * 256), 1'b0);
      chk("fill_level", 32'(level), 32'd8);
      chk("fill_full", 32'(ring_full), 32'd1);
      repeat (5) @(negedge clk);
      chk("no_9th_cmd", 32'(c.cmd_valid), 32'd0);
      chk("fill_idle", 32'(busy), 32'd0);

      // Drain all slots, then wrap the write pointer.
      in_prog_empty = 1'b1;
      out_prog_full = 1'b0;
      for (int i = 0; i < 8; i++) do_cmd(1'b0, 32'(i * 256), 1'b0);
      chk("drain_level", 32'(level), 32'd0);
      chk("drain_empty", 32'(ring_empty), 32'd1);
      in_prog_empty = 1'b0;
      out_prog_full = 1'b1;
      do_cmd(1'b1, 32'h000, 1'b0);
      chk("wrap_level", 32'(level), 32'd1);

      // Bring level to 4, then alternate with both sides eligible.
      do_cmd(1'b1, 32'h100, 1'b0);
      do_cmd(1'b1, 32'h200, 1'b0);
      do_cmd(1'b1, 32'h300, 1'b0);
      chk("alt_start_level", 32'(level), 32'd4);
      out_prog_full = 1'b0;
      do_cmd(1'b0, 32'h000, 1'b0);
      do_cmd(1'b1, 32'h400, 1'b0);
      do_cmd(1'b0, 32'h100, 1'b0);
      do_cmd(1'b1, 32'h500, 1'b0);
      chk("alt_end_level", 32'(level), 32'd4);

      // Error on a write, then recovery reissues the same address.
      out_prog_full = 1'b1;
      do_cmd(1'b1, 32'h600, 1'b1);
      chk("err_set", 32'(err), 32'd1);
      chk("err_level", 32'(level), 32'd4);
      repeat (3) @(negedge clk);
      chk("err_no_cmd", 32'(c.cmd_valid), 32'd0);
      chk("err_busy", 32'(busy), 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_cleared", 32'(err), 32'd0);
      do_cmd(1'b1, 32'h600, 1'b0);
      chk("err_retry_level", 32'(level), 32'd5);

      // Flush while a write is in flight.
      in_prog_empty = 1'b1;
      out_prog_full = 1'b0;
      do_cmd(1'b0, 32'h200, 1'b0);
      do_cmd(1'b0, 32'h300, 1'b0);
      chk("flush_pre_level", 32'(level), 32'd3);
      in_prog_empty = 1'b0;
      out_prog_full = 1'b1;
      wait_cmd(1'b1, 32'h700);
      handshake();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (2) @(negedge clk);
      chk("flush_hold_level", 32'(level), 32'd3);
      chk("flush_hold_busy", 32'(busy), 32'd1);
      finish_cmd(1'b0);
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_empty", 32'(ring_empty), 32'd1);
      do_cmd(1'b1, 32'h000, 1'b0);
      chk("post_flush_level", 32'(level), 32'd1);

      // Asynchronous reset while a command is being offered.
      wait_cmd(1'b1, 32'h100);
      #1;
      rst = 1'b1;
      #1;
      chk_reset_outs();
      @(negedge clk);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
